// File: rtl/mecanismo_puertas_if.sv
// Door-control interface: command and sensor toward the actuator,
// status, timeout and position back to the controller.
interface mecanismo_puertas_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       salida_puertas;
  logic             sensor;
  logic [1:0]       puertas;
  logic             timeout;
  logic [CNT_W-1:0] posicion;

  modport master (
    output salida_puertas,
    output sensor,
    input  puertas,
    input  timeout,
    input  posicion
  );

  modport slave (
    input  salida_puertas,
    input  sensor,
    output puertas,
    output timeout,
    output posicion
  );
endinterface

// File: rtl/mecanismo_puertas.sv
// Door actuator: travel position, open-dwell counter and timeout, all registered.
// Optional macro PUERTAS_SENSOR_REVERSA_EN: an obstruction while closing reverses the doors.
module mecanismo_puertas #(
  parameter int T_MOVE = 8,
  parameter int T_OPEN = 50,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  mecanismo_puertas_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'b00,
    ST_OPEN    = 2'b01,
    ST_CLOSING = 2'b10,
    ST_OPENING = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] POS_OPEN  = CNT_W'(T_MOVE);
  localparam logic [CNT_W-1:0] POS_LAST  = CNT_W'(T_MOVE - 1);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(T_OPEN);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] pos_n;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] dwell_n;
  logic             timeout_q;
  logic             timeout_n;
  logic             cmd_open;
  logic             cmd_close;
  logic             reversa;

  assign cmd_open  = (bus.salida_puertas == 2'b01);
  assign cmd_close = (bus.salida_puertas == 2'b10);

`ifdef PUERTAS_SENSOR_REVERSA_EN
  assign reversa = cmd_open | bus.sensor;
`else
  assign reversa = cmd_open;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLOSED;
      pos       <= '0;
      dwell     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      dwell     <= dwell_n;
      timeout_q <= timeout_n;
    end
  end

  // A reversal command wins over reaching the end stop on the same edge.
  always_comb begin
    state_n = state;
    case (state)
      ST_CLOSED:  if (cmd_open) state_n = ST_OPENING;
      ST_OPENING: begin
        if (cmd_close)            state_n = ST_CLOSING;
        else if (pos >= POS_LAST) state_n = ST_OPEN;
      end
      ST_OPEN:    if (cmd_close) state_n = ST_CLOSING;
      ST_CLOSING: begin
        if (reversa)         state_n = ST_OPENING;
        else if (pos <= ONE) state_n = ST_CLOSED;
      end
      default:    state_n = ST_CLOSED;
    endcase
  end

  // Position clamps to the end stops so a reversal at either end never wraps.
  always_comb begin
    pos_n   = pos;
    dwell_n = dwell;
    case (state)
      ST_OPENING: if (!cmd_close) pos_n = (pos >= POS_LAST) ? POS_OPEN : pos + ONE;
      ST_CLOSING: if (!reversa)   pos_n = (pos <= ONE) ? '0 : pos - ONE;
      ST_OPEN: begin
        if (cmd_open || bus.sensor) dwell_n = '0;
        else if (dwell < DWELL_MAX) dwell_n = dwell + ONE;
      end
      default: ;
    endcase
    if (state_n == ST_OPEN && state != ST_OPEN) dwell_n = '0;
    timeout_n = (state_n == ST_OPEN) && (dwell_n == DWELL_MAX);
  end

  assign bus.puertas  = state;
  assign bus.timeout  = timeout_q;
  assign bus.posicion = pos;

endmodule

// File: tb/tb_mecanismo_puertas.sv
// Scoreboard bench for mecanismo_puertas: directed door scenarios plus random
// commands, checked against a direction/position model of the door.
module tb_mecanismo_puertas;

  localparam int T_MOVE = 4;
  localparam int T_OPEN = 6;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [1:0]       puertas;
    logic             timeout;
    logic [CNT_W-1:0] posicion;
  } resp_t;

  logic clk = 1'b0;
  logic rst;

  mecanismo_puertas_if #(.CNT_W(CNT_W)) bus ();

  mecanismo_puertas #(
    .T_MOVE(T_MOVE),
    .T_OPEN(T_OPEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  resp_t expected_q[$];
  resp_t mon_exp;
  int    checks = 0;
  int    errors = 0;

  // Door model: direction of travel (+1 opening, -1 closing, 0 still),
  // position along the travel, and cycles spent resting fully open.
  int m_dir   = 0;
  int m_pos   = 0;
  int m_dwell = 0;
  bit sensor_reverses;

  task automatic modelStep(input bit r, input logic [1:0] cmd, input bit sens);
    bit want_open;
    bit want_close;
    want_open  = (cmd == 2'b01);
    want_close = (cmd == 2'b10);
    if (r) begin
      m_dir = 0; m_pos = 0; m_dwell = 0;
    end else if (m_dir > 0) begin
      if (want_close) m_dir = -1;
      else begin
        m_pos = m_pos + 1;
        if (m_pos >= T_MOVE) begin
          m_pos = T_MOVE; m_dir = 0; m_dwell = 0;
        end
      end
    end else if (m_dir < 0) begin
      if (want_open || (sensor_reverses && sens)) m_dir = 1;
      else begin
        m_pos = m_pos - 1;
        if (m_pos <= 0) begin
          m_pos = 0; m_dir = 0;
        end
      end
    end else if (m_pos == 0) begin
      if (want_open) m_dir = 1;
    end else begin
      if (want_close) m_dir = -1;
      else if (want_open || sens) m_dwell = 0;
      else if (m_dwell < T_OPEN) m_dwell = m_dwell + 1;
    end
  endtask

  function automatic resp_t modelResponse();
    resp_t r;
    if (m_dir > 0)           r.puertas = 2'b11;
    else if (m_dir < 0)      r.puertas = 2'b10;
    else if (m_pos == T_MOVE) r.puertas = 2'b01;
    else                     r.puertas = 2'b00;
    r.timeout  = (m_dir == 0) && (m_pos == T_MOVE) && (m_dwell == T_OPEN);
    r.posicion = CNT_W'(m_pos);
    return r;
  endfunction

  task automatic applyStimulus(input bit r, input logic [1:0] cmd, input bit sens);
    @(negedge clk);
    rst                = r;
    bus.salida_puertas = cmd;
    bus.sensor         = sens;
    modelStep(r, cmd, sens);
    expected_q.push_back(modelResponse());
  endtask

  task automatic hold(input logic [1:0] cmd, input bit sens, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, cmd, sens);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // Every cycle the DUT presents a fresh registered status; compare it to the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (expected_q.size() > 0) begin
      mon_exp = expected_q.pop_front();
      checkOutput("puertas",  32'(bus.puertas),  32'(mon_exp.puertas));
      checkOutput("timeout",  32'(bus.timeout),  32'(mon_exp.timeout));
      checkOutput("posicion", 32'(bus.posicion), 32'(mon_exp.posicion));
    end
  end

  initial begin
    logic [1:0] cmd;
    int         pick;
`ifdef PUERTAS_SENSOR_REVERSA_EN
    sensor_reverses = 1'b1;
`else
    sensor_reverses = 1'b0;
`endif
    rst                = 1'b1;
    bus.salida_puertas = 2'b00;
    bus.sensor         = 1'b0;

    applyStimulus(1'b1, 2'b00, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0);
    hold(2'b00, 1'b0, 20);

    // Full open, dwell into timeout, then close to the end stop.
    hold(2'b01, 1'b0, 1);
    hold(2'b00, 1'b0, 4);
    hold(2'b00, 1'b0, 7);
    hold(2'b10, 1'b0, 1);
    hold(2'b00, 1'b0, 5);

    // Reverse while closing at position 2.
    hold(2'b01, 1'b0, 1);
    hold(2'b00, 1'b0, 4);
    hold(2'b10, 1'b0, 1);
    hold(2'b00, 1'b0, 2);
    hold(2'b01, 1'b0, 1);
    hold(2'b00, 1'b0, 3);

    // Obstruction while open holds off the timeout.
    hold(2'b00, 1'b1, 10);
    hold(2'b00, 1'b0, 8);

    // Close from open, reopen, reset mid-opening.
    hold(2'b10, 1'b0, 5);
    hold(2'b01, 1'b0, 1);
    hold(2'b00, 1'b0, 1);
    applyStimulus(1'b1, 2'b00, 1'b0);
    hold(2'b00, 1'b0, 2);

    // Close command with obstruction while closing.
    hold(2'b01, 1'b0, 1);
    hold(2'b00, 1'b0, 4);
    hold(2'b10, 1'b0, 1);
    hold(2'b10, 1'b1, 6);
    hold(2'b11, 1'b0, 3);

    // Reversals at the very ends of travel.
    hold(2'b01, 1'b0, 1);
    hold(2'b10, 1'b0, 1);
    hold(2'b00, 1'b0, 2);

    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(99);
      if (pick < 70)      cmd = 2'b00;
      else if (pick < 82) cmd = 2'b01;
      else if (pick < 92) cmd = 2'b10;
      else                cmd = 2'b11;
      applyStimulus($urandom_range(99) < 2, cmd, $urandom_range(99) < 10);
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("drain", 32'(expected_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
